// File: rtl/meas_pkg.sv
// Shared definitions for the measurement readout path: SPI command opcodes,
// default buffer geometry and the bit layout of the {full, overflow, count}
// status word that the SPI decoder reports to the host.
package meas_pkg;

  // Read-side commands as they arrive from the SPI command decoder
  typedef enum logic [3:0] {
    READ_START = 4'b1100,
    READ       = 4'b1101,
    READ_LAST  = 4'b1110
  } spi_cmd_e;

  // Default geometry matches the 32 x 16 datamem this buffer replaces
  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_ADDR_W = 5;

  // Status word layout, LSB first: count (ADDR_W+1 bits), overflow, full
  localparam int STATUS_COUNT_LSB    = 0;
  localparam int STATUS_OVERFLOW_BIT = DEFAULT_ADDR_W + 1;
  localparam int STATUS_FULL_BIT     = DEFAULT_ADDR_W + 2;
  localparam int STATUS_W            = DEFAULT_ADDR_W + 3;

endpackage

// File: rtl/meas_readout_buffer_if.sv
// Bundle of sequencer write-side and SPI read-side signals for the readout
// buffer. The master modport is the sequencer/decoder side, slave is the buffer.
interface meas_readout_buffer_if
  import meas_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
);

  logic              measuring;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              ring_mode;
  logic              rd_start;
  logic              rd_next;
  logic              rd_last;
  logic              data_mode;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              overflow;

  modport master (
    output measuring, wr_en, wr_data, ring_mode, rd_start, rd_next, rd_last,
    input  data_mode, rd_data, count, full, overflow
  );

  modport slave (
    input  measuring, wr_en, wr_data, ring_mode, rd_start, rd_next, rd_last,
    output data_mode, rd_data, count, full, overflow
  );

endinterface

// File: rtl/meas_readout_buffer_dpram.sv
// Simple dual-port RAM: one write port and one registered read port.
// A read and a write to the same address in one cycle return the old word.
module readout_dpram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Storage array; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Registered read port, sampled before this cycle's write lands (read-first)
  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else     rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/meas_readout_buffer.sv
// Capture/readout buffer between the measurement sequencer and the SPI
// decoder. Holds all pointers, counters and flags; storage is readout_dpram.
// Single-shot mode drops words once full, ring mode overwrites the oldest.
module meas_readout_buffer
  import meas_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  meas_readout_buffer_if.slave  bus
);

  localparam int              DEPTH      = 2**ADDR_W;
  localparam logic [ADDR_W:0] LAST_COUNT = (ADDR_W+1)'(DEPTH - 1);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              overflow;
  logic              wrapped;
  logic              data_mode;
  logic              wr_accept;

  // A word is stored unless we are clearing or single-shot capture is full
  always_comb begin
    wr_accept = 1'b0;
    if (!reset && !bus.measuring && bus.wr_en)
      wr_accept = !full || bus.ring_mode;
  end

  // Write-side bookkeeping: pointer, count, full, wrap and sticky overflow
  always_ff @(posedge clk) begin
    if (reset || bus.measuring) begin
      wr_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
      wrapped  <= 1'b0;
    end else if (bus.wr_en) begin
      if (!full) begin
        wr_ptr <= wr_ptr + 1'b1;
        count  <= count + 1'b1;
        full   <= (count == LAST_COUNT);
      end else if (bus.ring_mode) begin
        wr_ptr   <= wr_ptr + 1'b1;
        wrapped  <= 1'b1;
        overflow <= 1'b1;
      end else begin
        overflow <= 1'b1;
      end
    end
  end

  // Read-side command handling; rd_start beats rd_next beats rd_last
  always_ff @(posedge clk) begin
    if (reset) begin
      data_mode <= 1'b0;
      rd_ptr    <= '0;
    end else if (bus.rd_start) begin
      data_mode <= 1'b1;
      rd_ptr    <= wrapped ? wr_ptr : '0;
    end else if (bus.rd_next) begin
      rd_ptr <= rd_ptr + 1'b1;
    end else if (bus.rd_last) begin
      data_mode <= 1'b0;
    end
  end

  readout_dpram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst     (reset),
    .we      (wr_accept),
    .wr_addr (wr_ptr),
    .wr_data (bus.wr_data),
    .rd_addr (rd_ptr),
    .rd_data (bus.rd_data)
  );

  assign bus.data_mode = data_mode;
  assign bus.count     = count;
  assign bus.full      = full;
  assign bus.overflow  = overflow;

endmodule

// File: tb/tb_meas_readout_buffer.sv
// Directed bench for meas_readout_buffer: single-shot and ring capture,
// measuring clear, read-first collision and read command priority.
module tb_meas_readout_buffer;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 5;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  meas_readout_buffer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  meas_readout_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // 10 ns system clock
  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle pulse of {wr_en, rd_start, rd_next, rd_last}
  task automatic applyStimulus(input logic [3:0] cmd, input logic [15:0] data);
    bus.wr_en    = cmd[3];
    bus.rd_start = cmd[2];
    bus.rd_next  = cmd[1];
    bus.rd_last  = cmd[0];
    bus.wr_data  = data;
    tick();
    bus.wr_en    = 1'b0;
    bus.rd_start = 1'b0;
    bus.rd_next  = 1'b0;
    bus.rd_last  = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clearCapture();
    bus.measuring = 1'b1;
    tick();
    bus.measuring = 1'b0;
  endtask

  localparam logic [3:0] WR = 4'b1000;
  localparam logic [3:0] ST = 4'b0100;
  localparam logic [3:0] NX = 4'b0010;
  localparam logic [3:0] LS = 4'b0001;

  initial begin
    bus.measuring = 1'b0;
    bus.wr_en     = 1'b0;
    bus.wr_data   = '0;
    bus.ring_mode = 1'b0;
    bus.rd_start  = 1'b0;
    bus.rd_next   = 1'b0;
    bus.rd_last   = 1'b0;
    reset         = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_data_mode", 32'(bus.data_mode), 32'd0);
    checkOutput("rst_count",     32'(bus.count),     32'd0);
    checkOutput("rst_full",      32'(bus.full),      32'd0);
    checkOutput("rst_overflow",  32'(bus.overflow),  32'd0);
    checkOutput("rst_rd_data",   32'(bus.rd_data),   32'd0);

    $display("[TB] three single-shot writes and readback");
    applyStimulus(WR, 16'h0A01);
    applyStimulus(WR, 16'h0A02);
    applyStimulus(WR, 16'h0A03);
    checkOutput("basic_count",    32'(bus.count),    32'd3);
    checkOutput("basic_full",     32'(bus.full),     32'd0);
    checkOutput("basic_overflow", 32'(bus.overflow), 32'd0);
    applyStimulus(ST, 16'h0);
    checkOutput("basic_data_mode", 32'(bus.data_mode), 32'd1);
    tick();
    checkOutput("basic_rd0", 32'(bus.rd_data), 32'h0A01);
    applyStimulus(NX, 16'h0);
    tick();
    checkOutput("basic_rd1", 32'(bus.rd_data), 32'h0A02);
    applyStimulus(NX, 16'h0);
    tick();
    checkOutput("basic_rd2", 32'(bus.rd_data), 32'h0A03);
    applyStimulus(LS, 16'h0);
    checkOutput("basic_last", 32'(bus.data_mode), 32'd0);

    $display("[TB] single-shot overfill");
    clearCapture();
    bus.ring_mode = 1'b0;
    for (int i = 0; i < 34; i++) applyStimulus(WR, 16'(i));
    checkOutput("ss_count",    32'(bus.count),    32'd32);
    checkOutput("ss_full",     32'(bus.full),     32'd1);
    checkOutput("ss_overflow", 32'(bus.overflow), 32'd1);
    applyStimulus(ST, 16'h0);
    for (int i = 0; i < 32; i++) begin
      tick();
      checkOutput($sformatf("ss_rd%0d", i), 32'(bus.rd_data), 32'(i));
      applyStimulus(NX, 16'h0);
    end
    applyStimulus(LS, 16'h0);

    $display("[TB] ring overfill");
    clearCapture();
    bus.ring_mode = 1'b1;
    for (int i = 0; i < 34; i++) applyStimulus(WR, 16'(i));
    checkOutput("ring_count",    32'(bus.count),    32'd32);
    checkOutput("ring_full",     32'(bus.full),     32'd1);
    checkOutput("ring_overflow", 32'(bus.overflow), 32'd1);
    applyStimulus(ST, 16'h0);
    tick();
    checkOutput("ring_rd0", 32'(bus.rd_data), 32'd2);
    for (int k = 1; k < 32; k++) begin
      int addr;
      addr = (2 + k) % 32;
      applyStimulus(NX, 16'h0);
      tick();
      checkOutput($sformatf("ring_rd%0d", k), 32'(bus.rd_data),
                  (addr < 2) ? 32'(addr + 32) : 32'(addr));
    end
    applyStimulus(LS, 16'h0);

    $display("[TB] measuring clears a full buffer");
    bus.ring_mode = 1'b0;
    bus.measuring = 1'b1;
    applyStimulus(WR, 16'hDEAD);
    checkOutput("meas_ignore_wr", 32'(bus.count), 32'd0);
    bus.measuring = 1'b0;
    checkOutput("meas_full",     32'(bus.full),     32'd0);
    checkOutput("meas_overflow", 32'(bus.overflow), 32'd0);
    applyStimulus(WR, 16'hBEEF);
    checkOutput("meas_count1", 32'(bus.count), 32'd1);
    applyStimulus(ST, 16'h0);
    tick();
    checkOutput("meas_first", 32'(bus.rd_data), 32'hBEEF);

    $display("[TB] read-first collision at address 5");
    applyStimulus(WR, 16'h1111);
    applyStimulus(WR, 16'h2222);
    applyStimulus(WR, 16'h3333);
    applyStimulus(WR, 16'h4444);
    for (int i = 0; i < 5; i++) applyStimulus(NX, 16'h0);
    tick();
    checkOutput("coll_before", 32'(bus.rd_data), 32'd5);
    applyStimulus(WR, 16'h5A5A);
    checkOutput("coll_same", 32'(bus.rd_data), 32'd5);
    tick();
    checkOutput("coll_next", 32'(bus.rd_data), 32'h5A5A);

    $display("[TB] command priority and reset in data mode");
    applyStimulus(LS, 16'h0);
    checkOutput("prio_idle", 32'(bus.data_mode), 32'd0);
    applyStimulus(ST | LS, 16'h0);
    checkOutput("prio_start_wins", 32'(bus.data_mode), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("rst2_data_mode", 32'(bus.data_mode), 32'd0);
    checkOutput("rst2_count",     32'(bus.count),     32'd0);
    checkOutput("rst2_rd_data",   32'(bus.rd_data),   32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
